// File: rtl/multiple_table_gen_pkg.sv
// Shared definitions for the digit-multiple table generator.
// Holds the FSM state encoding and the elaboration-time helpers that derive
// the table geometry (entry width, slice count, counter width) from the
// operand width, radix exponent and adder slice width.
package multiple_table_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ADD   = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Number of CHUNK-bit adder slices needed to cover an out_w-bit entry.
  function automatic int calc_nchunk(input int out_w, input int chunk);
    return (out_w + chunk - 1) / chunk;
  endfunction

  // Counter width for a count that runs 0..n-1, never narrower than one bit.
  function automatic int calc_cnt_w(input int n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multiple_table_gen_chunk_add_slice.sv
// chunk_add_slice: combinational CHUNK-bit adder with carry in and carry out.
// One slice of the chunk-serial odd-multiple adder; the carry register and
// slice selection live in the parent.
//   a, b  : CHUNK-bit addends
//   cin   : carry in from the previous slice
//   sum   : CHUNK-bit sum
//   cout  : carry out to the next slice
module chunk_add_slice #(
  parameter int CHUNK = 64
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/multiple_table_gen.sv
// multiple_table_gen: builds the digit-multiple table {0, A, 2A, ..., (NENT-1)*A}
// of operand A for a radix-2^DIGIT_BITS Montgomery multiplier.
// Even entries are a one-cycle left shift of entry[m/2]; odd entries are
// entry[m-1] + A computed CHUNK bits per cycle to keep the carry path short.
// The finished table is held until the next accepted start or reset.
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset, aborts any run
//   start    : one-cycle request, operand sampled on this edge (ignored while busy)
//   operand  : A, WIDTH bits
//   busy     : generation in progress
//   done     : one-cycle pulse when the table is complete
//   valid    : table contents valid
//   rd_sel   : entry index to read
//   rd_data  : entry[rd_sel], OUT_W bits, combinational read
module multiple_table_gen
  import multiple_table_gen_pkg::*;
#(
  parameter int WIDTH      = 1024,
  parameter int DIGIT_BITS = 2,
  parameter int CHUNK      = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [WIDTH-1:0]            operand,
  output logic                        busy,
  output logic                        done,
  output logic                        valid,
  input  logic [DIGIT_BITS-1:0]       rd_sel,
  output logic [WIDTH+DIGIT_BITS-1:0] rd_data
);

  localparam int OUT_W  = WIDTH + DIGIT_BITS;
  localparam int NCHUNK = calc_nchunk(OUT_W, CHUNK);
  localparam int PAD_W  = NCHUNK * CHUNK;
  localparam int NENT   = 1 << DIGIT_BITS;
  localparam int CNT_W  = calc_cnt_w(NCHUNK);
  // One extra bit so the entry index m can hold 2 even when DIGIT_BITS=1.
  localparam int M_W    = DIGIT_BITS + 1;

  state_t           state_q, state_d;
  logic [M_W-1:0]   m_q, m_d;
  logic [CNT_W-1:0] chunk_q, chunk_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic             load_a, wr_shift, wr_add, finish;

  // Entry 0 is a constant zero and is not stored. Entries are zero-padded
  // to PAD_W so every slice select is a full CHUNK; entry 1 doubles as A_ext.
  logic [PAD_W-1:0] tbl_q [1:NENT-1];

  logic [PAD_W-1:0] half_ent, prev_ent;
  logic [CHUNK-1:0] a_slice, b_slice, sum;
  logic             cout;
  logic [OUT_W-1:0] rd_word;

  // Source operands for the current entry: entry[m/2] for the shift,
  // entry[m-1] for the add.
  always_comb begin
    half_ent = '0;
    prev_ent = '0;
    for (int e = 1; e < NENT; e++) begin
      if ((m_q >> 1) == M_W'(e))        half_ent = tbl_q[e];
      if ((m_q - M_W'(1)) == M_W'(e))   prev_ent = tbl_q[e];
    end
  end

  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (chunk_q == CNT_W'(k)) begin
        a_slice = prev_ent[k*CHUNK +: CHUNK];
        b_slice = tbl_q[1][k*CHUNK +: CHUNK];
      end
    end
  end

  chunk_add_slice #(
    .CHUNK (CHUNK)
  ) u_add (
    .a    (a_slice),
    .b    (b_slice),
    .cin  (carry_q),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    chunk_d  = chunk_q;
    carry_d  = carry_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    load_a   = 1'b0;
    wr_shift = 1'b0;
    wr_add   = 1'b0;
    finish   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_a = 1'b1;
          if (NENT == 2) begin
            // Table is just {0, A}: complete on the start edge.
            done_d  = 1'b1;
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
            busy_d  = 1'b1;
            m_d     = M_W'(2);
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        wr_shift = 1'b1;
        if (m_q == M_W'(NENT - 1)) begin
          finish = 1'b1;
        end else begin
          m_d     = m_q + M_W'(1);
          chunk_d = '0;
          carry_d = 1'b0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        wr_add  = 1'b1;
        carry_d = cout;
        if (chunk_q == CNT_W'(NCHUNK - 1)) begin
          chunk_d = '0;
          if (m_q == M_W'(NENT - 1)) begin
            finish = 1'b1;
          end else begin
            m_d     = m_q + M_W'(1);
            state_d = ST_SHIFT;
          end
        end else begin
          chunk_d = chunk_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (finish) begin
      busy_d  = 1'b0;
      done_d  = 1'b1;
      valid_d = 1'b1;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      chunk_q <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int e = 1; e < NENT; e++) tbl_q[e] <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      chunk_q <= chunk_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      if (load_a) tbl_q[1] <= PAD_W'(operand);
      for (int e = 2; e < NENT; e++) begin
        if (wr_shift && (m_q == M_W'(e))) tbl_q[e] <= half_ent << 1;
        for (int k = 0; k < NCHUNK; k++) begin
          if (wr_add && (m_q == M_W'(e)) && (chunk_q == CNT_W'(k)))
            tbl_q[e][k*CHUNK +: CHUNK] <= sum;
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int e = 1; e < NENT; e++) begin
      if (rd_sel == DIGIT_BITS'(e)) rd_word = tbl_q[e][OUT_W-1:0];
    end
  end

  assign rd_data = rd_word;
  assign busy    = busy_q;
  assign done    = done_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_multiple_table_gen.sv
module tb_multiple_table_gen;
  localparam int W = 1024;

  logic clk = 1'b0;
  always #10 clk = ~clk;
  logic reset;

  // Default instance: DIGIT_BITS=2, CHUNK=64
  logic          start;
  logic [W-1:0]  operand;
  logic [1:0]    rd_sel;
  logic          busy, done, valid;
  logic [1025:0] rd_data;

  // DIGIT_BITS=3, CHUNK=128
  logic          start3;
  logic [W-1:0]  op3;
  logic [2:0]    sel3;
  logic          busy3, done3, valid3;
  logic [1026:0] rd3;

  // DIGIT_BITS=1
  logic          start1;
  logic [W-1:0]  op1;
  logic [0:0]    sel1;
  logic          busy1, done1, valid1;
  logic [1024:0] rd1;

  multiple_table_gen #(.WIDTH(W), .DIGIT_BITS(2), .CHUNK(64)) dut (
    .clk(clk), .reset(reset), .start(start), .operand(operand), .busy(busy),
    .done(done), .valid(valid), .rd_sel(rd_sel), .rd_data(rd_data));

  multiple_table_gen #(.WIDTH(W), .DIGIT_BITS(3), .CHUNK(128)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .operand(op3), .busy(busy3),
    .done(done3), .valid(valid3), .rd_sel(sel3), .rd_data(rd3));

  multiple_table_gen #(.WIDTH(W), .DIGIT_BITS(1), .CHUNK(64)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .operand(op1), .busy(busy1),
    .done(done1), .valid(valid1), .rd_sel(sel1), .rd_data(rd1));

  int n_cmp = 0;
  int n_fail = 0;
  logic [1025:0] got2 [4];
  logic [1026:0] got3 [8];
  logic [1024:0] got1 [2];

  // Reference model: entry m is simply m*A at full width.
  function automatic logic [1025:0] exp2(input logic [W-1:0] a, input int m);
    return 1026'(a) * 1026'(m);
  endfunction
  function automatic logic [1026:0] exp3(input logic [W-1:0] a, input int m);
    return 1027'(a) * 1027'(m);
  endfunction
  function automatic logic [1024:0] exp1(input logic [W-1:0] a, input int m);
    return 1025'(a) * 1025'(m);
  endfunction

  function automatic logic [W-1:0] rand_a();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic read2();
    for (int i = 0; i < 4; i++) begin rd_sel = 2'(i); #1; got2[i] = rd_data; end
  endtask
  task automatic read3();
    for (int i = 0; i < 8; i++) begin sel3 = 3'(i); #1; got3[i] = rd3; end
  endtask
  task automatic read1();
    for (int i = 0; i < 2; i++) begin sel1 = 1'(i); #1; got1[i] = rd1; end
  endtask

  // Leaves the bench at the negedge just after the start edge; operand is
  // scrambled afterwards since A must be held internally.
  task automatic start2(input logic [W-1:0] a);
    @(negedge clk); start = 1'b1; operand = a;
    @(negedge clk); start = 1'b0; operand = rand_a();
  endtask

  // Counts negedges after the start edge until done is seen (bounded).
  task automatic wait2(inout int lat);
    while (done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; operand = rand_a();
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    start = 1'b0; reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_busy got %b exp 0", busy); end
    read2();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got2[i] !== '0) begin n_fail++; $display("FAIL reset_entry%0d got lo=%h exp 0", i, got2[i][63:0]); end
    end
  endtask

  task automatic test_basic();
    int lat = 0;
    start2(1024'd1);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b exp 1", busy); end
    wait2(lat);
    n_cmp++; if (lat != 18) begin n_fail++; $display("FAIL basic_latency got %0d exp 18", lat); end
    n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b exp 0", busy); end
    read2();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got2[i] !== 1026'(i)) begin n_fail++; $display("FAIL basic_entry%0d got %h exp %0d", i, got2[i][63:0], i); end
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_all_ones();
    logic [W-1:0] a;
    int lat = 0;
    a = '1;
    start2(a);
    wait2(lat);
    n_cmp++; if (lat != 18) begin n_fail++; $display("FAIL ones_latency got %0d exp 18", lat); end
    read2();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got2[i] !== exp2(a, i)) begin
        n_fail++;
        $display("FAIL ones_entry%0d got hi=%h lo=%h exp hi=%h lo=%h", i, got2[i][1025 -: 16], got2[i][63:0],
                 exp2(a, i) >> 1010, exp2(a, i) & 1026'({64{1'b1}}));
      end
    end
    n_cmp++; if (dut.carry_q !== 1'b0) begin n_fail++; $display("FAIL ones_top_carry got %b exp 0", dut.carry_q); end
  endtask

  task automatic test_ignored_restart();
    logic [W-1:0] a1, a2;
    int lat, ndone;
    a1 = rand_a(); a2 = rand_a();
    start2(a1);
    repeat (4) @(negedge clk);
    start = 1'b1; operand = a2;
    @(negedge clk); start = 1'b0;
    lat = 5;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy got %b exp 1", busy); end
    wait2(lat);
    n_cmp++; if (lat != 18) begin n_fail++; $display("FAIL restart_latency got %0d exp 18", lat); end
    read2();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got2[i] !== exp2(a1, i)) begin n_fail++; $display("FAIL restart_entry%0d got lo=%h exp lo=%h", i, got2[i][63:0], exp2(a1, i) & 1026'({64{1'b1}})); end
    end
    ndone = 0;
    repeat (25) begin @(negedge clk); if (done === 1'b1) ndone++; end
    n_cmp++; if (ndone != 0) begin n_fail++; $display("FAIL restart_extra_done got %0d exp 0", ndone); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] a;
    int lat = 0;
    start2(rand_a());
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy); end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b exp 0", valid); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b exp 0", done); end
    read2();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got2[i] !== '0) begin n_fail++; $display("FAIL abort_entry%0d got lo=%h exp 0", i, got2[i][63:0]); end
    end
    a = rand_a();
    start2(a);
    wait2(lat);
    n_cmp++; if (lat != 18) begin n_fail++; $display("FAIL abort_restart_latency got %0d exp 18", lat); end
    read2();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got2[i] !== exp2(a, i)) begin n_fail++; $display("FAIL abort_restart_entry%0d got lo=%h exp lo=%h", i, got2[i][63:0], exp2(a, i) & 1026'({64{1'b1}})); end
    end
  endtask

  task automatic test_start_in_done();
    logic [W-1:0] a1, a2;
    int lat = 0;
    a1 = rand_a(); a2 = rand_a();
    start2(a1);
    wait2(lat);
    start = 1'b1; operand = a2;
    @(negedge clk); start = 1'b0; operand = rand_a();
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL done_start_valid got %b exp 0", valid); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL done_start_busy got %b exp 1", busy); end
    lat = 0;
    wait2(lat);
    n_cmp++; if (lat != 18) begin n_fail++; $display("FAIL done_start_latency got %0d exp 18", lat); end
    read2();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got2[i] !== exp2(a2, i)) begin n_fail++; $display("FAIL done_start_entry%0d got lo=%h exp lo=%h", i, got2[i][63:0], exp2(a2, i) & 1026'({64{1'b1}})); end
    end
  endtask

  task automatic test_random2();
    logic [W-1:0] a;
    for (int t = 0; t < 20; t++) begin
      int lat = 0;
      a = rand_a();
      start2(a);
      wait2(lat);
      n_cmp++; if (lat != 18) begin n_fail++; $display("FAIL rand2_latency it%0d got %0d exp 18", t, lat); end
      read2();
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (got2[i] !== exp2(a, i)) begin n_fail++; $display("FAIL rand2_entry%0d it%0d got lo=%h exp lo=%h", i, t, got2[i][63:0], exp2(a, i) & 1026'({64{1'b1}})); end
      end
    end
  endtask

  task automatic test_digit3();
    logic [W-1:0] a;
    for (int t = 0; t < 100; t++) begin
      int lat = 0;
      a = rand_a();
      @(negedge clk); start3 = 1'b1; op3 = a;
      @(negedge clk); start3 = 1'b0; op3 = rand_a();
      while (done3 !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
      n_cmp++; if (lat != 30) begin n_fail++; $display("FAIL d3_latency it%0d got %0d exp 30", t, lat); end
      read3();
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (got3[i] !== exp3(a, i)) begin n_fail++; $display("FAIL d3_entry%0d it%0d got lo=%h exp lo=%h", i, t, got3[i][63:0], exp3(a, i) & 1027'({64{1'b1}})); end
      end
    end
  endtask

  task automatic test_digit1();
    logic [W-1:0] a;
    for (int t = 0; t < 10; t++) begin
      a = rand_a();
      @(negedge clk); start1 = 1'b1; op1 = a;
      @(negedge clk); start1 = 1'b0; op1 = rand_a();
      n_cmp++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL d1_done got %b exp 1", done1); end
      n_cmp++; if (valid1 !== 1'b1) begin n_fail++; $display("FAIL d1_valid got %b exp 1", valid1); end
      n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL d1_busy got %b exp 0", busy1); end
      read1();
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (got1[i] !== exp1(a, i)) begin n_fail++; $display("FAIL d1_entry%0d it%0d got lo=%h exp lo=%h", i, t, got1[i][63:0], exp1(a, i) & 1025'({64{1'b1}})); end
      end
      @(negedge clk);
      n_cmp++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL d1_done_pulse got %b exp 0", done1); end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; operand = '0; rd_sel = '0;
    start3 = 1'b0; op3 = '0; sel3 = '0;
    start1 = 1'b0; op1 = '0; sel1 = '0;
    test_reset();
    test_basic();
    test_all_ones();
    test_ignored_restart();
    test_reset_mid();
    test_start_in_done();
    test_random2();
    test_digit3();
    test_digit1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
